// File: rtl/dmem_port_arbiter_if.sv
// Request/grant/read-return bundle between the two dmem requesters, the arbiter and the dmem syncram.
// The arbiter takes the slave modport; requesters plus the syncram side take the master modport.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              p_req;
  logic              p_wren;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic              p_gnt;
  logic              p_rvalid;
  logic [DATA_W-1:0] p_q;

  logic              d_req;
  logic              d_wren;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_q;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  logic [3:0]        starve_cnt;

  modport slave (
    input  p_req, p_wren, p_addr, p_data,
    input  d_req, d_wren, d_addr, d_data,
    input  mem_q,
    output p_gnt, p_rvalid, p_q,
    output d_gnt, d_rvalid, d_q,
    output mem_address, mem_data, mem_wren,
    output starve_cnt
  );

  modport master (
    output p_req, p_wren, p_addr, p_data,
    output d_req, d_wren, d_addr, d_data,
    output mem_q,
    input  p_gnt, p_rvalid, p_q,
    input  d_gnt, d_rvalid, d_q,
    input  mem_address, mem_data, mem_wren,
    input  starve_cnt
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem syncram between the processor (P) and a debug/loader port (D).
// Default: P fixed priority with a starvation counter; `define DMEM_ARB_RR_EN for round-robin.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_P    = 2'd1,
    RD_D    = 2'd2
  } rd_owner_t;

  rd_owner_t         r_rd_owner;
  rd_owner_t         w_rd_owner_next;

  logic              w_both;
  logic              w_p_win;
  logic              w_d_win;
  logic              w_p_gnt;
  logic              w_d_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_wren;

  assign w_both = bus.p_req & bus.d_req;

`ifdef DMEM_ARB_RR_EN
  logic r_last_d;
  logic w_last_d_next;

  // Under contention the port that did not win last time wins now.
  always_comb begin
    w_p_win       = bus.p_req & (~bus.d_req | r_last_d);
    w_d_win       = bus.d_req & ~w_p_win;
    w_last_d_next = r_last_d;
    if (w_both) begin
      w_last_d_next = w_d_win;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_d <= 1'b1;
    end else begin
      r_last_d <= w_last_d_next;
    end
  end

  assign bus.starve_cnt = 4'd0;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_next;

  always_comb begin
    w_p_win       = bus.p_req & (~bus.d_req | (r_starve_cnt != LIMIT));
    w_d_win       = bus.d_req & ~w_p_win;
    w_starve_next = r_starve_cnt;
    if (w_d_win) begin
      w_starve_next = 4'd0;
    end else if (bus.d_req && (r_starve_cnt < LIMIT)) begin
      w_starve_next = r_starve_cnt + 4'd1;
    end
  end

  // Held while D is idle, so a saturated count makes D win its very next contention.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= 4'd0;
    end else begin
      r_starve_cnt <= w_starve_next;
    end
  end

  assign bus.starve_cnt = r_starve_cnt;
`endif

  // Grants and writes are gated directly by reset so nothing issues while it is low.
  assign w_p_gnt = w_p_win & reset;
  assign w_d_gnt = w_d_win & reset;

  assign w_addr = w_d_win ? bus.d_addr : bus.p_addr;
  assign w_data = w_d_win ? bus.d_data : bus.p_data;
  assign w_wren = w_d_win ? bus.d_wren : bus.p_wren;

  assign bus.p_gnt       = w_p_gnt;
  assign bus.d_gnt       = w_d_gnt;
  assign bus.mem_address = w_addr;
  assign bus.mem_data    = w_data;
  assign bus.mem_wren    = w_wren & (w_p_gnt | w_d_gnt);

  // Owner of the read that the syncram is returning this cycle.
  always_comb begin
    w_rd_owner_next = RD_NONE;
    if (w_p_gnt && !bus.p_wren) begin
      w_rd_owner_next = RD_P;
    end else if (w_d_gnt && !bus.d_wren) begin
      w_rd_owner_next = RD_D;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_owner <= RD_NONE;
    end else begin
      r_rd_owner <= w_rd_owner_next;
    end
  end

  assign bus.p_rvalid = (r_rd_owner == RD_P);
  assign bus.d_rvalid = (r_rd_owner == RD_D);
  assign bus.p_q      = bus.mem_q;
  assign bus.d_q      = bus.mem_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random two-port traffic
// against a transaction-level model of arbitration, the memory contents and read return.
module tb_dmem_port_arbiter;
  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int DEPTH        = 1 << ADDR_W;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Syncram with a registered read.
  logic [DATA_W-1:0] sram [0:DEPTH-1];
  always @(posedge clock) begin
    if (bus.mem_wren) sram[bus.mem_address] <= bus.mem_data;
    bus.mem_q <= sram[bus.mem_address];
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  int                m_starve;
  bit                m_last_d;
  bit                m_p_rv;
  bit                m_d_rv;
  logic [DATA_W-1:0] m_rdata;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  bit                obs_p_gnt, obs_d_gnt, obs_p_rv, obs_d_rv;
  logic [DATA_W-1:0] obs_p_q, obs_d_q;
  logic [3:0]        obs_starve;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_last_d = 1'b1;
    m_p_rv   = 1'b0;
    m_d_rv   = 1'b0;
    m_rdata  = '0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model, return at next posedge+1.
  task automatic step(input bit pr, input bit pw, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                      input bit dr, input bit dw, input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd,
                      output bit gp, output bit gd);
    bit                ep, ed;
    logic [ADDR_W-1:0] a;
    int                exp_starve;
    bus.p_req = pr; bus.p_wren = pw; bus.p_addr = pa; bus.p_data = pd;
    bus.d_req = dr; bus.d_wren = dw; bus.d_addr = da; bus.d_data = dd;
    ep = pr;
    ed = dr;
    if (pr && dr) begin
`ifdef DMEM_ARB_RR_EN
      ep = m_last_d;
`else
      ep = (m_starve != STARVE_LIMIT);
`endif
      ed = !ep;
    end
`ifdef DMEM_ARB_RR_EN
    exp_starve = 0;
`else
    exp_starve = m_starve;
`endif
    @(negedge clock);
    obs_p_gnt = bus.p_gnt; obs_d_gnt = bus.d_gnt;
    obs_p_rv  = bus.p_rvalid; obs_d_rv = bus.d_rvalid;
    obs_p_q   = bus.p_q; obs_d_q = bus.d_q;
    obs_starve = bus.starve_cnt;
    check("p_gnt", bus.p_gnt, ep);
    check("d_gnt", bus.d_gnt, ed);
    check("mem_wren", bus.mem_wren, (ep & pw) | (ed & dw));
    check("mem_address", bus.mem_address, ed ? da : pa);
    check("mem_data", bus.mem_data, ed ? dd : pd);
    check("starve_cnt", bus.starve_cnt, exp_starve);
    check("p_rvalid", bus.p_rvalid, m_p_rv);
    check("d_rvalid", bus.d_rvalid, m_d_rv);
    if (m_p_rv) check("p_q", bus.p_q, m_rdata);
    if (m_d_rv) check("d_q", bus.d_q, m_rdata);
    $display("[TB] cyc %0d P(req=%0b we=%0b a=%03h) D(req=%0b we=%0b a=%03h) gnt P=%0b D=%0b starve=%0d",
             cyc, pr, pw, pa, dr, dw, da, bus.p_gnt, bus.d_gnt, bus.starve_cnt);
    m_p_rv = ep && !pw;
    m_d_rv = ed && !dw;
    if (ep || ed) begin
      a = ed ? da : pa;
      if ((ep && pw) || (ed && dw)) ref_mem[a] = ed ? dd : pd;
      else                          m_rdata    = ref_mem[a];
    end
    if (ed)                                   m_starve = 0;
    else if (dr && m_starve < STARVE_LIMIT)   m_starve++;
    if (pr && dr) m_last_d = ed;
    gp = ep;
    gd = ed;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bit gp, gd;
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, gp, gd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit                gp, gd;
    bit                pp, dp, pw_r, dw_r;
    logic [ADDR_W-1:0] pa_r, da_r;
    logic [DATA_W-1:0] pd_r, dd_r;
    bit                exp_pg [6];
    int                exp_st [6];

    model_reset();

    // Reset held with a pending P write: nothing may issue.
    bus.p_req = 1'b1; bus.p_wren = 1'b1; bus.p_addr = 12'h020; bus.p_data = 32'h1234_5678;
    bus.d_req = 1'b0; bus.d_wren = 1'b0; bus.d_addr = '0;     bus.d_data = '0;
    repeat (2) @(negedge clock);
    check("rst_p_gnt", bus.p_gnt, 1'b0);
    check("rst_mem_wren", bus.mem_wren, 1'b0);
    check("rst_p_rvalid", bus.p_rvalid, 1'b0);
    check("rst_d_rvalid", bus.d_rvalid, 1'b0);
    check("rst_starve", bus.starve_cnt, 4'd0);
    reset = 1'b1;
    #1;
    check("rel_p_gnt", bus.p_gnt, 1'b1);
    check("rel_mem_wren", bus.mem_wren, 1'b1);
    ref_mem[12'h020] = 32'h1234_5678;
    @(posedge clock);
    #1;

    // Starvation: both request continuously.
`ifdef DMEM_ARB_RR_EN
    exp_pg = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_st = '{0, 0, 0, 0, 0, 0};
`else
    exp_pg = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_st = '{0, 1, 2, 3, 4, 0};
`endif
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, ADDR_W'(12'h100 + i), DATA_W'(32'hA000_0000 + i),
           1'b1, 1'b1, 12'h200, 32'hD0D0_0000, gp, gd);
      check("starve_seq_p_gnt", obs_p_gnt, exp_pg[i]);
      check("starve_seq_d_gnt", obs_d_gnt, !exp_pg[i]);
      check("starve_seq_cnt", obs_starve, exp_st[i]);
    end
    idle();

    // P write then read of the same address on the next cycle.
    step(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0, gp, gd);
    check("wr_p_gnt", obs_p_gnt, 1'b1);
    step(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0, gp, gd);
    check("rd_p_gnt", obs_p_gnt, 1'b1);
    idle();
    check("wr_rd_p_rvalid", obs_p_rv, 1'b1);
    check("wr_rd_p_q", obs_p_q, 32'hDEAD_BEEF);
    check("wr_rd_d_rvalid", obs_d_rv, 1'b0);

    // D preload of 0..15 with value addr+1, then back-to-back reads of 0,1,2.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, ADDR_W'(i), DATA_W'(i + 1), gp, gd);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, ADDR_W'(i), '0, gp, gd);
      else       idle();
      if (i < 3) check("d_b2b_gnt", obs_d_gnt, 1'b1);
      if (i > 0) begin
        check("d_b2b_rvalid", obs_d_rv, 1'b1);
        check("d_b2b_q", obs_d_q, DATA_W'(i));
      end
    end

    // Reset pulsed while a D read is in flight.
    bus.p_req = 1'b0; bus.d_req = 1'b1; bus.d_wren = 1'b0; bus.d_addr = 12'h005;
    @(negedge clock);
    check("midrst_d_gnt", bus.d_gnt, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_gnt_forced", bus.d_gnt, 1'b0);
    @(posedge clock);
    #1;
    bus.d_req = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("midrst_d_rvalid", bus.d_rvalid, 1'b0);
    check("midrst_starve", bus.starve_cnt, 4'd0);
    model_reset();
    @(posedge clock);
    #1;
    idle();

    // Random traffic; a requester holds its request until granted.
    pp = 1'b0; dp = 1'b0;
    pw_r = 1'b0; dw_r = 1'b0; pa_r = '0; da_r = '0; pd_r = '0; dd_r = '0;
    repeat (400) begin
      if (!pp && $urandom_range(0, 3) != 0) begin
        pp = 1'b1; pw_r = 1'($urandom_range(0, 1));
        pa_r = ADDR_W'($urandom_range(0, 15)); pd_r = $urandom;
      end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1'b1; dw_r = 1'($urandom_range(0, 1));
        da_r = ADDR_W'($urandom_range(0, 15)); dd_r = $urandom;
      end
      step(pp, pw_r, pa_r, pd_r, dp, dw_r, da_r, dd_r, gp, gd);
      if (gp) pp = 1'b0;
      if (gd) dp = 1'b0;
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port dmem syncram between two requesters: the processor (port P) and a debug/loader port (port D) used for memory preload and inspection.
- Port P has fixed priority. A starvation counter guarantees that port D is served.
- Read data is returned with the syncram's 1-cycle latency and is tagged to the requester that issued the read.
- Sits between the processor's dmem outputs and the dmem instance, on the dmem clock domain.

Parameters:
- ADDR_W, 12, dmem address width
- DATA_W, 32, data word width
- STARVE_LIMIT, 4, consecutive denied D-cycles before D is forced to win (range 1..15)

Ports:
- clock  input  1  dmem clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- p_req  input  1  processor access request
- p_wren  input  1  processor write enable (valid with p_req)
- p_addr  input  ADDR_W  processor address
- p_data  input  DATA_W  processor write data
- p_gnt  output  1  processor access issued this cycle
- p_rvalid  output  1  p_q holds read data for P's read granted last cycle
- p_q  output  DATA_W  read data to processor
- d_req, d_wren, d_addr, d_data  input  1/1/ADDR_W/DATA_W  debug port request, same meaning as P
- d_gnt, d_rvalid, d_q  output  1/1/DATA_W  debug port grant, read valid, read data
- mem_address  output  ADDR_W  to dmem address
- mem_data  output  DATA_W  to dmem data
- mem_wren  output  1  to dmem wren
- mem_q  input  DATA_W  from dmem q
- starve_cnt  output  4  current starvation count (observability)

Behaviour:
- Reset (reset=0, asynchronous):
  - p_rvalid=0, d_rvalid=0, starve_cnt=0, rd_owner register cleared.
  - p_gnt=0, d_gnt=0 and mem_wren=0 are forced while reset is low.
- Arbitration is combinational within the cycle:
  - Only P requests: P wins.
  - Only D requests: D wins.
  - Both request: P wins unless starve_cnt==STARVE_LIMIT, in which case D wins.
  - No request: no grant, mem_wren=0, mem_address/mem_data hold P's inputs.
- Issue:
  - The winner's addr/data/wren drive mem_* in the same cycle.
  - The winner's gnt=1 in that cycle, and the loser's gnt=0.
  - mem_wren = winner_wren & winner_req.
  - A requester not granted holds req/addr/data/wren stable until it sees gnt.
- Starvation counter, updated at the clock edge:
  - Cleared to 0 when D is granted.
  - Incremented (saturating at STARVE_LIMIT) when d_req=1 and D is not granted.
  - Held when d_req=0.
- Read return:
  - A granted read (wren=0) sets the registered rvalid of that port to 1 in the next cycle; the other port's rvalid is 0.
  - A write never sets rvalid.
  - p_q and d_q both equal mem_q combinationally; only the owning port's rvalid qualifies it.
  - A read issued every cycle yields rvalid every cycle (fully pipelined, throughput 1 access/cycle).
- Boundaries:
  - Write followed by a read of the same address on the next cycle returns the new data; ordering is preserved by the single port.
  - Reset asserted mid-read: the pending rvalid is dropped and no data is returned after reset is released.
  - A P write and a D read in the same cycle: P's write is performed and D retries.
  - STARVE_LIMIT reached while d_req drops: the counter holds, and D wins immediately on its next request if P also requests.
- Latency: grant at 0 cycles; read data at 1 cycle after grant.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined:
  - Fixed priority and the starvation counter are replaced by round-robin.
  - A last_winner register (reset value = D, so P wins the first contention) alternates the winner on each contended cycle.
  - starve_cnt output is tied to 0.
- Not defined: fixed priority with starvation counter as described above.

Test Plan:
- Reset: hold reset=0, drive p_req=1, p_wren=1 -> p_gnt=0, mem_wren=0, p_rvalid=0, starve_cnt=0; release reset -> p_gnt=1 the same cycle.
- P write/read: P writes 0xDEADBEEF to 0x010, then reads 0x010 on the next cycle -> p_gnt=1 both cycles; p_rvalid=1 one cycle after the read; p_q=0xDEADBEEF; d_rvalid=0.
- Starvation: p_req and d_req held high for 6 cycles with STARVE_LIMIT=4 -> P granted cycles 0-3, starve_cnt 1,2,3,4; D granted cycle 4 with starve_cnt→0; P granted cycle 5.
- D-only back-to-back reads of 0x000,0x001,0x002 preloaded with 1,2,3 -> d_gnt=1 each cycle; d_rvalid=1 on the following 3 cycles with d_q=1,2,3.
- Reset mid-read: D read granted, reset pulsed low before the next edge -> d_rvalid stays 0 and starve_cnt=0.
- With DMEM_ARB_RR_EN and both requesting for 4 cycles -> grants P,D,P,D; starve_cnt=0 throughout.
